// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter in front of one shared W-bit register.
// Requesters load the register one at a time. The register holds its
// value with valid/owner tags until the consumer asserts take.

// Per-requester data lane: passes its requester's slice only when selected,
// so the shared-register input is a plain AND-OR of all lanes.
module shared_reg_arbiter_lane #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = din & {W{sel}};
endmodule

module shared_reg_arbiter #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   wdata,
  input  logic             take,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     q,
  output logic             q_valid,
  output logic [IDX_W-1:0] q_owner,
  output logic             busy
);

  localparam logic [0:0]       EMPTY    = 1'b0;
  localparam logic [0:0]       FULL     = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [0:0]            state;
  logic [IDX_W-1:0]      last;
  logic [IDX_W-1:0]      win;
  logic                  found;
  logic [N-1:0]          win_oh;
  logic [N-1:0][W-1:0]   lane_q;
  logic [W-1:0]          win_data;
  logic                  load;

  // Rotating search starting just after the last winner; the pointer wraps
  // by compare so non-power-of-two N works.
  always_comb begin
    logic [IDX_W-1:0] ptr;
    ptr   = last;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      ptr = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
      if (!found && req[ptr]) begin
        found = 1'b1;
        win   = ptr;
      end
    end
  end

  assign win_oh = N'(1) << win;
  assign load   = (state == EMPTY) && found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      shared_reg_arbiter_lane #(.W(W)) u_lane (
        .sel  (win_oh[gi]),
        .din  (wdata[gi*W +: W]),
        .dout (lane_q[gi])
      );
    end
  endgenerate

  // OR-combine the masked lanes; at most one lane is selected.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) win_data = win_data | lane_q[i];
  end

  // State, pointer, shared register and one-cycle grant pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      last    <= LAST_IDX;
      q       <= '0;
      q_owner <= '0;
      gnt     <= '0;
    end else begin
      gnt <= '0;
      case (state)
        EMPTY: begin
          if (load) begin
            state   <= FULL;
            q       <= win_data;
            q_owner <= win;
            last    <= win;
            gnt     <= win_oh;
          end
        end
        default: begin
          // q and q_owner stay put on take; only the valid tag drops.
          if (take) state <= EMPTY;
        end
      endcase
    end
  end

  assign q_valid = (state == FULL);
  assign busy    = q_valid;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a cycle-level reference model of the arbitration rules.
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic             take;
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             q_valid;
  logic [IDX_W-1:0] q_owner;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_valid;
  int       m_q, m_owner, m_last;
  int       m_gnt;

  shared_reg_arbiter #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .take(take),
    .gnt(gnt), .q(q), .q_valid(q_valid), .q_owner(q_owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_q = 0; m_owner = 0; m_last = N - 1; m_gnt = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs held over it.
  task automatic model_edge();
    bit done;
    m_gnt = 0;
    if (!m_valid) begin
      done = 0;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!done && req[i]) begin
          done    = 1;
          m_valid = 1;
          m_q     = (wdata >> (i * W)) & 'hFF;
          m_owner = i;
          m_last  = i;
          m_gnt   = 1 << i;
        end
      end
    end else if (take) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, int'(q), m_q);
    chk({tag, ".q_valid"}, int'(q_valid), int'(m_valid));
    chk({tag, ".q_owner"}, int'(q_owner), m_owner);
    chk({tag, ".gnt"}, int'(gnt), m_gnt);
    chk({tag, ".busy"}, int'(busy), int'(m_valid));
  endtask

  // Advance one edge, update model, compare shortly after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; take = 1'b0; wdata = '0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int order [$];
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int exp_qs    [5] = '{'h11, 'h22, 'h33, 'h44, 'h11};
  int qs [$];
  bit saw_g1;

  initial begin
    rst_n = 1'b0; req = '0; take = 1'b0; wdata = '0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk); rst_n = 1'b1;

    // all request, take every time valid
    req = 4'b1111; wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 10; c++) begin
      step("rr");
      if (gnt != 0) begin order.push_back($clog2(gnt)); qs.push_back(q); end
      take = q_valid;
    end
    chk("rr.ngrants", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      chk("rr.order", order[k], exp_order[k]);
      chk("rr.qseq", qs[k], exp_qs[k]);
    end

    // single requester, held 20 cycles with no take
    do_reset();
    req = 4'b0100; wdata = 32'h00A5_0000;
    step("single");
    chk("single.gnt", int'(gnt), 4);
    chk("single.q", int'(q), 'hA5);
    chk("single.owner", int'(q_owner), 2);
    for (int c = 0; c < 20; c++) step("single_hold");
    chk("single.valid", int'(q_valid), 1);

    // take and new request on the same edge
    do_reset();
    req = 4'b0001; wdata = 32'h0000_BB77;
    step("tk_a");
    req = 4'b0010; take = 1'b1;
    step("tk_b");
    chk("tk.nogrant", int'(gnt), 0);
    chk("tk.empty", int'(q_valid), 0);
    take = 1'b0;
    step("tk_c");
    chk("tk.next_gnt", int'(gnt), 2);
    chk("tk.next_q", int'(q), 'hBB);

    // withdrawn request while full never granted
    do_reset();
    saw_g1 = 0;
    req = 4'b0001; wdata = 32'h0000_3C01;
    step("wd_a");
    req = 4'b0010; step("wd_b"); saw_g1 |= gnt[1];
    req = 4'b0000; step("wd_c"); saw_g1 |= gnt[1];
    take = 1'b1;   step("wd_d"); saw_g1 |= gnt[1];
    take = 1'b0;
    for (int c = 0; c < 4; c++) begin step("wd_e"); saw_g1 |= gnt[1]; end
    chk("wd.no_g1", int'(saw_g1), 0);
    chk("wd.empty", int'(q_valid), 0);

    // async reset mid-cycle while full
    do_reset();
    req = 4'b0001; wdata = 32'h0000_005A;
    step("ar_a");
    req = '0;
    step("ar_b");
    chk("ar.q_before", int'(q), 'h5A);
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar.q", int'(q), 0);
    chk("ar.valid", int'(q_valid), 0);
    chk("ar.gnt", int'(gnt), 0);
    req = 4'b1010; wdata = 32'hD000_C000 | 32'h0000_9900;
    @(negedge clk); rst_n = 1'b1;
    step("ar_c");
    chk("ar.first", int'(q_owner), 1);
    chk("ar.first_gnt", int'(gnt), 2);

    // take while empty, no requests
    do_reset();
    req = '0; take = 1'b1;
    for (int c = 0; c < 10; c++) step("idle");
    chk("idle.q", int'(q), 0);
    take = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      req   = N'($urandom);
      take  = ($urandom_range(0, 2) != 0);
      wdata = $urandom;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
Round-robin arbiter and sequencer for a single shared W-bit data register built from D flip-flops. Up to N requesters compete to load the register. One winner is granted per load. The register then holds its value, with valid and owner tags, until a single consumer takes it. The block sits between several producer blocks and one consumer and serializes their writes into the shared storage element.

Parameters:
N, 4, number of requesters (2..16)
W, 8, data width of each requester and of the shared register
IDX_W, $clog2(N), width of the owner index

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  per-requester load request, bit i = requester i
wdata  input  N*W  packed write data; requester i uses bits [i*W +: W]
take  input  1  consumer acknowledges and empties the register
gnt  output  N  one-hot, one-cycle grant pulse to the winning requester
q  output  W  shared register contents
q_valid  output  1  register holds unconsumed data
q_owner  output  IDX_W  index of the requester whose data is in q
busy  output  1  equals q_valid; provided for producer back-pressure

Behaviour:
- Reset: rst_n low asynchronously forces q=0, q_valid=0, q_owner=0, gnt=0, state=EMPTY, and last-winner pointer=N-1. As a result, requester 0 has top priority after reset.
- Reset mid-operation discards held data. Any in-flight grant is dropped, with no gnt pulse.
- FSM states: EMPTY (q_valid=0) and FULL (q_valid=1).
- EMPTY, req==0: remain EMPTY, gnt=0.
- EMPTY, req!=0:
  - Winner = first set req bit searching from index (last+1) mod N upward, wrapping.
  - On the same rising edge: q <= wdata[winner], q_owner <= winner, q_valid <= 1, last <= winner, gnt[winner] <= 1 for exactly one cycle. Next state FULL.
  - Latency: req sampled at edge k; gnt, q and q_valid visible after edge k, i.e. in cycle k+1.
- FULL, take=0: hold q, q_owner and q_valid. gnt=0. Requests are ignored.
- FULL, take=1: q_valid <= 0 and next state EMPTY. q keeps its last value (not cleared), q_owner is held, gnt=0.
  - A req present in the same cycle is NOT granted that cycle. The earliest next grant is one cycle after the take edge, so the minimum load-to-load spacing is 2 cycles.
- take while EMPTY: ignored, no state change.
- Handshake rules:
  - A requester holds req and its wdata stable until it sees its gnt bit.
  - A requester may deassert req before grant; this withdraws the request with no side effect.
  - After gnt, a requester that keeps req high is treated as a new request.
- Fairness: a continuously requesting source waits at most N-1 loads between grants.
- gnt is always one-hot or zero, and never asserted while q_valid was 1 in the preceding cycle.
- No arithmetic beyond the pointer increment: wraps N-1 -> 0 with a modulo compare, valid for non-power-of-two N.

Test Plan:
- Reset then req=4'b1111, wdata={8'h44,8'h33,8'h22,8'h11}, take pulsed each time q_valid=1 -> grant order 0,1,2,3,0; q sequence 11,22,33,44,11; each gnt one cycle wide.
- Single requester: req=4'b0100, wdata[2]=8'hA5, no take -> gnt=4'b0100 for one cycle, q=A5, q_owner=2, q_valid stays 1 for 20 cycles, gnt stays 0 throughout.
- Take and new req in the same cycle while FULL -> q_valid=0 for exactly one cycle; the grant appears on the following edge, never on the take edge.
- Requester 1 raises req then drops it while the register is FULL held by requester 0 -> no gnt[1] ever; after take, state EMPTY with q_valid=0.
- rst_n driven low asynchronously mid-cycle while FULL with q=8'h5A -> q=0, q_valid=0, gnt=0 immediately, without waiting for a clk edge. After release with req=4'b1010 -> requester 1 is granted first.
- Take while EMPTY and req=0 for 10 cycles -> all outputs stay at reset values.
